// File: rtl/pipe_buffer.sv
// rtl/pipe_buffer.sv - DEPTH-entry elastic pipeline buffer with valid/ready, flush and occupancy
// Optional same-cycle pass-through when empty: define PIPE_BUFFER_BYPASS_EN.
module pipe_buffer #(
  parameter int              WIDTH = 32,
  parameter int              DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             held;
  logic             full;
  logic             passthru;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign held     = (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = cnt;

`ifdef PIPE_BUFFER_BYPASS_EN
  logic bypass;

  // An empty buffer presents the producer's entry directly; a taken
  // pass-through never touches storage or the count.
  assign bypass    = !held && in_valid && !flush;
  assign passthru  = bypass && out_ready;
  assign out_valid = held || bypass;
  assign dout      = held ? mem[rd_ptr] : (bypass ? din : INIT);
`else
  assign passthru  = 1'b0;
  assign out_valid = held;
  assign dout      = held ? mem[rd_ptr] : INIT;
`endif

  assign push = in_valid && !full && !flush && !passthru;
  assign pop  = held && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT;
      end
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_buffer.sv
// tb/tb_pipe_buffer.sv - directed self-checking bench for pipe_buffer (DEPTH 2 and DEPTH 3)
module tb_pipe_buffer;

  logic       clk;
  logic       rst;

  logic       fl2, iv2, ir2, ov2, or2;
  logic [7:0] din2, dout2;
  logic [1:0] cnt2;

  logic       fl3, iv3, ir3, ov3, or3;
  logic [7:0] din3, dout3;
  logic [1:0] cnt3;

  int n_total;
  int n_pass;

  pipe_buffer #(.WIDTH(8), .DEPTH(2), .INIT(8'hC3)) u_buf2 (
    .clk(clk), .rst(rst), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .din(din2),
    .out_valid(ov2), .out_ready(or2), .dout(dout2), .count(cnt2)
  );

  pipe_buffer #(.WIDTH(8), .DEPTH(3), .INIT(8'hEE)) u_buf3 (
    .clk(clk), .rst(rst), .flush(fl3),
    .in_valid(iv3), .in_ready(ir3), .din(din3),
    .out_valid(ov3), .out_ready(or3), .dout(dout3), .count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    fl2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; din2 = 8'h00;
    fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; din3 = 8'h00;
    #12;
    chk("rst2_count", cnt2, 0);
    chk("rst2_ov", ov2, 0);
    chk("rst2_ir", ir2, 1);
    chk("rst2_dout", dout2, 8'hC3);
    chk("rst3_dout", dout3, 8'hEE);
    rst = 1'b0;

    // fill DEPTH=2 with consumer stalled; third entry must be held back
    iv2 = 1'b1; din2 = 8'h0A;
    tick();
    chk("fill_a_count", cnt2, 1);
    chk("fill_a_ov", ov2, 1);
    chk("fill_a_dout", dout2, 8'h0A);
    din2 = 8'h0B;
    tick();
    chk("fill_b_count", cnt2, 2);
    chk("fill_b_ir", ir2, 0);
    din2 = 8'h0C;
    tick();
    chk("full_hold_count", cnt2, 2);
    chk("full_hold_dout", dout2, 8'h0A);
    or2 = 1'b1;
    tick();
    chk("full_pop_count", cnt2, 1);
    chk("full_pop_ir", ir2, 1);
    chk("drain_b", dout2, 8'h0B);
    tick();
    chk("pushpop_count", cnt2, 1);
    chk("drain_c", dout2, 8'h0C);
    iv2 = 1'b0;
    tick();
    chk("empty_count", cnt2, 0);
    chk("empty_ov", ov2, 0);
    chk("empty_dout", dout2, 8'hC3);

    // flush while full with producer active
    or2 = 1'b0; iv2 = 1'b1; din2 = 8'h01;
    tick();
    din2 = 8'h02;
    tick();
    chk("pre_flush_count", cnt2, 2);
    fl2 = 1'b1; din2 = 8'h77; or2 = 1'b1;
    tick();
    chk("flush_count", cnt2, 0);
    chk("flush_ov", ov2, 0);
    chk("flush_dout", dout2, 8'hC3);
    fl2 = 1'b0; iv2 = 1'b0; or2 = 1'b0;
    tick();
    chk("post_flush_count", cnt2, 0);
    iv2 = 1'b1; din2 = 8'h99;
    tick();
    iv2 = 1'b0;
    chk("post_flush_push", dout2, 8'h99);
    chk("post_flush_push_cnt", cnt2, 1);

    // flush with room: the flush-cycle push must be discarded
    fl2 = 1'b1; iv2 = 1'b1; din2 = 8'h22;
    tick();
    fl2 = 1'b0; iv2 = 1'b0;
    chk("flush1_count", cnt2, 0);
    tick();
    chk("flush1_ov", ov2, 0);
    chk("flush1_dout", dout2, 8'hC3);

    // empty buffer, producer and consumer both ready
    iv2 = 1'b1; din2 = 8'h55; or2 = 1'b1;
    #1;
`ifdef PIPE_BUFFER_BYPASS_EN
    chk("byp_same_ov", ov2, 1);
    chk("byp_same_dout", dout2, 8'h55);
`else
    chk("byp_same_ov", ov2, 0);
    chk("byp_same_dout", dout2, 8'hC3);
`endif
    tick();
`ifdef PIPE_BUFFER_BYPASS_EN
    chk("byp_next_count", cnt2, 0);
`else
    chk("byp_next_count", cnt2, 1);
`endif
    chk("byp_next_dout", dout2, 8'h55);
    iv2 = 1'b0;
    tick();
    chk("byp_end_count", cnt2, 0);

    // asynchronous reset mid-stream with two entries held
    or2 = 1'b0; iv2 = 1'b1; din2 = 8'h31;
    tick();
    din2 = 8'h32;
    tick();
    iv2 = 1'b0;
    chk("mid_pre_count", cnt2, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", ov2, 0);
    chk("mid_rst_dout", dout2, 8'hC3);
    chk("mid_rst_count", cnt2, 0);
    chk("mid_rst_ir", ir2, 1);
    rst = 1'b0;
    tick();

    // DEPTH=3 streaming, pointers wrap several times
    or3 = 1'b1; iv3 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      din3 = 8'(k);
      tick();
      chk($sformatf("stream_dout_%0d", k), dout3, k);
`ifdef PIPE_BUFFER_BYPASS_EN
      chk($sformatf("stream_cnt_%0d", k), cnt3, 0);
`else
      chk($sformatf("stream_cnt_%0d", k), cnt3, 1);
`endif
      chk($sformatf("stream_ir_%0d", k), ir3, 1);
    end
    iv3 = 1'b0;
    tick();
    chk("stream_end_count", cnt3, 0);
    chk("stream_end_dout", dout3, 8'hEE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
